// File: rtl/alu_issue_collect.sv
// Issue/collect front end for a set of three ALU units sharing one operand bus.
// Captures a request, strobes the selected unit, then waits for its result or a timeout.
module alu_issue_collect #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_unit,
    input  logic [3:0]              in_opcode,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    input  logic [3:0]              in_dst,
    output logic [2:0]              unit_data_valid,
    output logic [3:0]              unit_opcode,
    output logic [DATA_WIDTH-1:0]   unit_data_a,
    output logic [DATA_WIDTH-1:0]   unit_data_b,
    input  logic [2:0]              unit_result_valid,
    input  logic [3*DATA_WIDTH-1:0] unit_result,
    input  logic [11:0]             unit_flags,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_result,
    output logic [3:0]              out_flags,
    output logic [3:0]              out_dst,
    output logic                    out_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    // Counter holds completed WAIT cycles, so the last allowed cycle sees TIMEOUT-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [1:0]              unit_q, unit_d;
    logic [3:0]              opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [3:0]              dst_q, dst_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [3:0]              flags_q, flags_d;
    logic                    error_q, error_d;
    logic [7:0]              cnt_q, cnt_d;

    logic                    accept;
    logic                    sel_valid;
    logic [DATA_WIDTH-1:0]   sel_result;
    logic [3:0]              sel_flags;
    logic [2:0]              onehot;

    always_comb begin
        sel_valid  = 1'b0;
        sel_result = '0;
        sel_flags  = '0;
        onehot     = '0;
        case (unit_q)
            2'd0: begin
                sel_valid  = unit_result_valid[0];
                sel_result = unit_result[0 +: DATA_WIDTH];
                sel_flags  = unit_flags[3:0];
                onehot     = 3'b001;
            end
            2'd1: begin
                sel_valid  = unit_result_valid[1];
                sel_result = unit_result[DATA_WIDTH +: DATA_WIDTH];
                sel_flags  = unit_flags[7:4];
                onehot     = 3'b010;
            end
            2'd2: begin
                sel_valid  = unit_result_valid[2];
                sel_result = unit_result[2*DATA_WIDTH +: DATA_WIDTH];
                sel_flags  = unit_flags[11:8];
                onehot     = 3'b100;
            end
            default: ;
        endcase
    end

    assign accept = in_valid && (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        unit_d   = unit_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        dst_d    = dst_q;
        result_d = result_q;
        flags_d  = flags_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unit_d   = in_unit;
                    opcode_d = in_opcode;
                    a_d      = in_a;
                    b_d      = in_b;
                    dst_d    = in_dst;
                    cnt_d    = '0;
                    if (in_unit == 2'd3) begin
                        state_d  = S_HOLD;
                        result_d = '0;
                        flags_d  = '0;
                        error_d  = 1'b1;
                    end else begin
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (sel_valid) begin
                    state_d  = S_HOLD;
                    result_d = sel_result;
                    flags_d  = sel_flags;
                    error_d  = 1'b0;
                end else begin
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sel_valid) begin
                    state_d  = S_HOLD;
                    result_d = sel_result;
                    flags_d  = sel_flags;
                    error_d  = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = S_HOLD;
                    result_d = '0;
                    flags_d  = '0;
                    error_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            unit_q   <= '0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dst_q    <= dst_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready        = (state_q == S_IDLE);
    assign unit_data_valid = (state_q == S_ISSUE) ? onehot : 3'b000;
    assign unit_opcode     = opcode_q;
    assign unit_data_a     = a_q;
    assign unit_data_b     = b_q;
    assign out_valid       = (state_q == S_HOLD);
    assign out_result      = result_q;
    assign out_flags       = flags_q;
    assign out_dst         = dst_q;
    assign out_error       = error_q;

endmodule
